dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
- Data-memory stage that consumes the processor's MEM-stage bus: MemRd, MemWr, dataAddr, datain. It returns dataout.
- Word-addressed 16-bit RAM plus a small memory-mapped I/O window at the top of the address space.
- The window holds an output port, a synchronized input port and a free-running 32-bit cycle counter with atomic high-word capture.
- Sits directly beside the cpu top in the system wrapper. The instruction memory is a separate block.

Parameters:
- DEPTH, 1024: number of 16-bit RAM words. Power of two, at most 32768.
- MMIO_BASE, 16'hFFF0: word address of the first MMIO register. The window is 16 words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRd  input  1  read strobe from the cpu.
- MemWr  input  1  write strobe from the cpu.
- dataAddr  input  16  word address.
- datain  input  16  write data (cpu to memory).
- dataout  output  16  read data (memory to cpu), combinational from the address.
- io_in  input  16  external input pins, asynchronous.
- io_out  output  16  output-port register.
- err  output  1  sticky access-error flag.
- init_busy  output  1  RAM clear sweep in progress. Tied 0 when DMEM_CLEAR_EN is not defined.

Behaviour:
- Region decode:
  - RAM: dataAddr < DEPTH.
  - MMIO: MMIO_BASE <= dataAddr <= MMIO_BASE+15.
  - Everything else is unmapped.
- Reads:
  - dataout is valid in the same cycle MemRd is high; the cpu samples it before the edge.
  - When MemRd=0, dataout = 16'h0000.
  - RAM read returns the stored word.
  - Read-during-write to the same address returns the old word; the write commits at the edge.
- Writes:
  - Committed on the rising edge when MemWr=1, the region is writable and reset=0.
- MMIO map (offset from MMIO_BASE):
  - 0: OUT, R/W. io_out follows it.
  - 1: IN, RO. io_in passed through a 2-flop synchronizer.
  - 2: CNT_LO, RO. Reading it (MemRd edge) latches CNT[31:16] into a shadow register.
  - 3: CNT_HI, RO. Returns the shadow, not live CNT.
  - 4: ERR, R/W1C. Bit0 = err; writing datain[0]=1 clears it.
  - 5..15: reserved. Read 0; a write sets err.
- Cycle counter:
  - CNT is 32 bits, increments every cycle and wraps 32'hFFFFFFFF to 0.
  - Shadow update happens on the edge closing a cycle with MemRd=1 and offset 2.
- err is set on:
  - any access (read or write) to an unmapped address;
  - a write to a RO register or a reserved offset;
  - MemRd and MemWr both high in the same cycle.
- Precedence for simultaneous MemRd and MemWr:
  - The write proceeds if legal.
  - dataout = 0.
  - err is set.
- err clear vs set: if a W1C clear and a new error source occur in the same cycle, set wins.
- Reset values:
  - io_out = 0, err = 0, CNT = 0, shadow = 0, synchronizer flops = 0.
  - dataout follows the reset-state decode.
  - RAM contents are not reset unless DMEM_CLEAR_EN is defined.
- Reset asserted mid-sweep or mid-access: pending writes are dropped and all registers return to reset values on that edge.

Optional Feature:
- DMEM_CLEAR_EN defined:
  - After reset deasserts, an FSM sweeps the RAM writing 0 to one word per cycle, addresses 0..DEPTH-1.
  - FSM states: IDLE, CLEAR, DONE. Reset forces CLEAR with pointer 0. CLEAR moves to DONE after address DEPTH-1 is written.
  - init_busy = 1 while in CLEAR. The sweep takes exactly DEPTH cycles after the first non-reset edge.
  - During CLEAR, cpu RAM writes are ignored and set err; RAM reads return 0. MMIO stays fully functional.
- DMEM_CLEAR_EN not defined:
  - No FSM; init_busy = 0.
  - RAM is uninitialised (X in simulation).

Decomposition:
- Package dmem_pkg holds:
  - MMIO offset localparams: OFF_OUT=0, OFF_IN=1, OFF_CNT_LO=2, OFF_CNT_HI=3, OFF_ERR=4;
  - MMIO_SPAN=16;
  - clear-FSM state encodings.
- One sub-module, dmem_ram: single-port array with a combinational read and a synchronous write port, parameterised by DEPTH.
- The MMIO decode, counter, synchronizer and clear FSM live in dmem_mmio.

Test Plan:
- RAM round-trip: write 16'hBEEF to addr 5, then MemRd addr 5 next cycle -> dataout=BEEF. In the same cycle as the write, read addr 5 -> old value.
- Output port: write 16'h00A5 to MMIO_BASE+0 -> io_out=00A5 after the edge. Read back -> 00A5. Assert reset -> io_out=0.
- Input sync: drive io_in=16'h1234. Read MMIO_BASE+1 one cycle later -> stale value; two edges later -> 1234.
- Counter atomicity:
  - Force CNT to 32'h0001FFFF (after 131071 cycles, or via a bench hierarchical write).
  - Read CNT_LO -> FFFF; read CNT_HI next cycle -> 0001, even though live CNT is now 0002_xxxx.
- Error handling:
  - MemRd=MemWr=1 to addr 3 -> dataout=0, err=1 next edge.
  - Write to 16'h8000 -> err stays 1.
  - Write 1 to MMIO_BASE+4 -> err=0.
- DMEM_CLEAR_EN with DEPTH=16:
  - Release reset -> init_busy high for exactly 16 cycles.
  - A cpu write during the sweep -> ignored and err=1.
  - Afterwards every RAM address reads 0.
  - Reset asserted at sweep cycle 7 -> the sweep restarts at 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory stage: MMIO offsets, window span and clear-FSM states.
package dmem_pkg;

    localparam logic [3:0] OFF_OUT    = 4'd0;
    localparam logic [3:0] OFF_IN     = 4'd1;
    localparam logic [3:0] OFF_CNT_LO = 4'd2;
    localparam logic [3:0] OFF_CNT_HI = 4'd3;
    localparam logic [3:0] OFF_ERR    = 4'd4;

    localparam int unsigned MMIO_SPAN = 16;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } clr_state_e;

endpackage

// File: rtl/dmem_mmio_if.sv
// MEM-stage bus between the cpu (master) and the data memory (slave).
interface dmem_mmio_if;
    logic        MemRd;
    logic        MemWr;
    logic [15:0] dataAddr;
    logic [15:0] datain;
    logic [15:0] dataout;

    modport master (output MemRd, output MemWr, output dataAddr, output datain, input dataout);
    modport slave  (input MemRd, input MemWr, input dataAddr, input datain, output dataout);
endinterface

// File: rtl/dmem_ram.sv
// Single-port 16-bit RAM: combinational read, synchronous write, no reset of contents.
module dmem_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read sees the pre-edge contents, so read-during-write returns the old word.
    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: RAM plus MMIO window (OUT, synced IN, 32-bit counter, sticky ERR).
// Optional power-on RAM clear sweep is enabled by defining DMEM_CLEAR_EN.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic        err,
    output logic        init_busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          in_ram;
    logic          in_mmio;
    logic [16:0]   mmio_off;
    logic [3:0]    off;
    logic          clearing;
    logic [AW-1:0] clr_addr;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;

    logic [15:0]   out_q;
    logic [15:0]   sync1_q;
    logic [15:0]   sync2_q;
    logic [31:0]   cnt_q;
    logic [15:0]   shadow_q;
    logic          err_q;
    logic          err_d;
    logic          out_we;
    logic          shadow_le;
    logic [15:0]   rdata;

    // 17-bit offset keeps the window check correct even when MMIO_BASE sits near 16'hFFFF.
    assign mmio_off = {1'b0, bus.dataAddr} - {1'b0, MMIO_BASE};
    assign in_mmio  = (bus.dataAddr >= MMIO_BASE) && (mmio_off < 17'(MMIO_SPAN));
    assign in_ram   = 32'(bus.dataAddr) < DEPTH;
    assign off      = mmio_off[3:0];

`ifdef DMEM_CLEAR_EN
    clr_state_e    state_q;
    logic [AW-1:0] ptr_q;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StClear;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
                StClear: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clearing = busy_q;
    assign clr_addr = ptr_q;
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign init_busy = clearing;

    // The sweep owns the RAM port; cpu writes are dropped while it runs.
    assign ram_we    = !reset && (clearing || (bus.MemWr && in_ram));
    assign ram_addr  = clearing ? clr_addr : bus.dataAddr[AW-1:0];
    assign ram_wdata = clearing ? 16'h0000 : bus.datain;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign out_we    = bus.MemWr && in_mmio && (off == OFF_OUT);
    assign shadow_le = bus.MemRd && in_mmio && (off == OFF_CNT_LO);

    always_comb begin
        err_d = err_q;
        if (bus.MemWr && in_mmio && (off == OFF_ERR) && bus.datain[0]) begin
            err_d = 1'b0;
        end
        // Any new error source overrides a same-cycle W1C clear.
        if (((bus.MemRd || bus.MemWr) && !in_ram && !in_mmio) ||
            (bus.MemWr && in_mmio && (off != OFF_OUT) && (off != OFF_ERR)) ||
            (bus.MemWr && in_ram && clearing) ||
            (bus.MemRd && bus.MemWr)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + 32'd1;
            sync1_q <= io_in;
            sync2_q <= sync1_q;
            err_q   <= err_d;
            if (out_we) begin
                out_q <= bus.datain;
            end
            if (shadow_le) begin
                shadow_q <= cnt_q[31:16];
            end
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (in_ram) begin
            rdata = clearing ? 16'h0000 : ram_rdata;
        end else if (in_mmio) begin
            case (off)
                OFF_OUT:    rdata = out_q;
                OFF_IN:     rdata = sync2_q;
                OFF_CNT_LO: rdata = cnt_q[15:0];
                OFF_CNT_HI: rdata = shadow_q;
                OFF_ERR:    rdata = {15'd0, err_q};
                default:    rdata = 16'h0000;
            endcase
        end
        bus.dataout = (bus.MemRd && !bus.MemWr) ? rdata : 16'h0000;
    end

    assign io_out = out_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio; covers the clear sweep when DMEM_CLEAR_EN is defined.
module tb_dmem_mmio;
    import dmem_pkg::*;

`ifdef DMEM_CLEAR_EN
    localparam int unsigned Depth = 16;
    localparam logic BusyAtReset = 1'b1;
`else
    localparam int unsigned Depth = 1024;
    localparam logic BusyAtReset = 1'b0;
`endif
    localparam logic [15:0] Base = 16'hFFF0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] io_in = 16'h0000;
    logic [15:0] io_out;
    logic        err;
    logic        init_busy;
    int          checks = 0;
    int          errors = 0;

    dmem_mmio_if bus ();

    dmem_mmio #(
        .DEPTH     (Depth),
        .MMIO_BASE (Base)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .io_in     (io_in),
        .io_out    (io_out),
        .err       (err),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge and are committed by the following rising edge.
    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.MemRd    = rd;
        bus.MemWr    = wr;
        bus.dataAddr = a;
        bus.datain   = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic clear_err();
        drive(1'b0, 1'b1, Base + 16'd4, 16'h0001);
        idle();
    endtask

`ifdef DMEM_CLEAR_EN
    task automatic count_busy(output int n, input int wr_at);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!init_busy) break;
            n++;
            if (i == wr_at) drive(1'b0, 1'b1, 16'd2, 16'hBEEF);
            else idle();
        end
    endtask

    task automatic clear_test();
        int n;
        reset = 1'b1;
        idle();
        idle();
        @(negedge clk);
        reset = 1'b0;
        count_busy(n, 10);
        check("busy_cycles", 32'(n), 32'd16);
        idle();
        check("sweep_wr_err", {31'd0, err}, 32'd1);
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 16'(a), 16'h0000);
            #1 check($sformatf("cleared_%0d", a), {16'd0, bus.dataout}, 32'h0);
        end
        // Reset in the middle of the sweep restarts it from address 0.
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
        repeat (7) idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        count_busy(n, -1);
        check("busy_restart", 32'(n), 32'd16);
        check("err_after_restart", {31'd0, err}, 32'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MemRd = 1'b0;
        bus.MemWr = 1'b0;
        bus.dataAddr = 16'h0000;
        bus.datain = 16'h0000;

        // Reset state, and a write during reset is dropped
        idle();
        drive(1'b0, 1'b1, Base, 16'hFFFF);
        idle();
        #1;
        check("rst_io_out", {16'd0, io_out}, 32'h0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_dout", {16'd0, bus.dataout}, 32'h0);
        check("rst_busy", {31'd0, init_busy}, {31'd0, BusyAtReset});

        // Counter starts at 0 on the first cycle after reset
        drive(1'b1, 1'b0, Base + 16'd2, 16'h0000);
        reset = 1'b0;
        #1 check("cnt_first", {16'd0, bus.dataout}, 32'h0000);
        drive(1'b1, 1'b0, Base + 16'd2, 16'h0000);
        #1 check("cnt_second", {16'd0, bus.dataout}, 32'h0001);
        drive(1'b1, 1'b0, Base + 16'd3, 16'h0000);
        #1 check("cnt_hi_rst", {16'd0, bus.dataout}, 32'h0000);

`ifdef DMEM_CLEAR_EN
        clear_test();
        clear_err();
`endif

        // RAM round-trip and read-during-write
        drive(1'b0, 1'b1, 16'd5, 16'h1111);
        drive(1'b1, 1'b0, 16'd5, 16'h0000);
        #1 check("ram_rd_1111", {16'd0, bus.dataout}, 32'h1111);
        drive(1'b0, 1'b1, 16'd5, 16'hBEEF);
        #1 check("ram_rdw_old", {16'd0, dut.ram_rdata}, 32'h1111);
        drive(1'b1, 1'b0, 16'd5, 16'h0000);
        #1 check("ram_rd_beef", {16'd0, bus.dataout}, 32'hBEEF);
        drive(1'b0, 1'b1, 16'd6, 16'h0042);
        drive(1'b1, 1'b0, 16'd6, 16'h0000);
        #1 check("ram_rd_6", {16'd0, bus.dataout}, 32'h0042);
        drive(1'b0, 1'b0, 16'd5, 16'h0000);
        #1 check("dout_no_rd", {16'd0, bus.dataout}, 32'h0);

        // Output port
        drive(1'b0, 1'b1, Base, 16'h00A5);
        drive(1'b1, 1'b0, Base, 16'h0000);
        #1;
        check("io_out_a5", {16'd0, io_out}, 32'h00A5);
        check("out_rd", {16'd0, bus.dataout}, 32'h00A5);

        // Input synchronizer: two edges of latency
        drive(1'b1, 1'b0, Base + 16'd1, 16'h0000);
        io_in = 16'h1234;
        #1 check("in_stale0", {16'd0, bus.dataout}, 32'h0000);
        drive(1'b1, 1'b0, Base + 16'd1, 16'h0000);
        #1 check("in_stale1", {16'd0, bus.dataout}, 32'h0000);
        drive(1'b1, 1'b0, Base + 16'd1, 16'h0000);
        #1 check("in_synced", {16'd0, bus.dataout}, 32'h1234);
        check("err_clean", {31'd0, err}, 32'd0);

        // Error handling
        drive(1'b0, 1'b1, Base + 16'd1, 16'h5555);
        idle();
        check("wr_ro_err", {31'd0, err}, 32'd1);
        drive(1'b1, 1'b0, Base + 16'd4, 16'h0000);
        #1 check("err_reg_rd", {16'd0, bus.dataout}, 32'h0001);
        drive(1'b0, 1'b1, Base + 16'd4, 16'h0000);
        idle();
        check("w1c_zero", {31'd0, err}, 32'd1);
        clear_err();
        check("w1c_one", {31'd0, err}, 32'd0);
        drive(1'b0, 1'b1, Base + 16'd7, 16'h0001);
        drive(1'b1, 1'b0, Base + 16'd7, 16'h0000);
        #1 check("rsvd_rd", {16'd0, bus.dataout}, 32'h0);
        check("rsvd_wr_err", {31'd0, err}, 32'd1);
        clear_err();
        drive(1'b1, 1'b1, Base + 16'd3, 16'h1234);
        #1 check("rdwr_dout", {16'd0, bus.dataout}, 32'h0);
        idle();
        check("rdwr_err", {31'd0, err}, 32'd1);
        drive(1'b0, 1'b1, 16'h8000, 16'h0000);
        idle();
        check("unmapped_wr", {31'd0, err}, 32'd1);
        drive(1'b1, 1'b1, Base + 16'd4, 16'h0001);
        idle();
        check("set_beats_clr", {31'd0, err}, 32'd1);
        clear_err();
        drive(1'b1, 1'b0, 16'(Depth - 1), 16'h0000);
        idle();
        check("ram_top_ok", {31'd0, err}, 32'd0);
        drive(1'b1, 1'b0, 16'(Depth), 16'h0000);
        #1 check("ram_end_dout", {16'd0, bus.dataout}, 32'h0);
        idle();
        check("ram_end_err", {31'd0, err}, 32'd1);
        clear_err();
        drive(1'b1, 1'b0, Base - 16'd1, 16'h0000);
        idle();
        check("below_base_err", {31'd0, err}, 32'd1);
        clear_err();
        check("io_out_kept", {16'd0, io_out}, 32'h00A5);

        // Counter atomicity across a 16-bit carry and across the 32-bit wrap
        idle();
        dut.cnt_q = 32'h0001_FFFE;
        drive(1'b1, 1'b0, Base + 16'd2, 16'h0000);
        #1 check("cnt_lo_ffff", {16'd0, bus.dataout}, 32'hFFFF);
        drive(1'b1, 1'b0, Base + 16'd3, 16'h0000);
        #1 check("cnt_hi_shadow", {16'd0, bus.dataout}, 32'h0001);
        drive(1'b1, 1'b0, Base + 16'd2, 16'h0000);
        #1 check("cnt_lo_next", {16'd0, bus.dataout}, 32'h0001);
        drive(1'b1, 1'b0, Base + 16'd3, 16'h0000);
        #1 check("cnt_hi_next", {16'd0, bus.dataout}, 32'h0002);
        idle();
        dut.cnt_q = 32'hFFFF_FFFE;
        drive(1'b1, 1'b0, Base + 16'd2, 16'h0000);
        #1 check("wrap_lo", {16'd0, bus.dataout}, 32'hFFFF);
        drive(1'b1, 1'b0, Base + 16'd3, 16'h0000);
        #1 check("wrap_hi_shadow", {16'd0, bus.dataout}, 32'hFFFF);
        drive(1'b1, 1'b0, Base + 16'd2, 16'h0000);
        #1 check("wrap_lo_after", {16'd0, bus.dataout}, 32'h0001);
        drive(1'b1, 1'b0, Base + 16'd3, 16'h0000);
        #1 check("wrap_hi_after", {16'd0, bus.dataout}, 32'h0000);

        // Reset returns registers to their reset values
        drive(1'b0, 1'b1, 16'h8000, 16'h0000);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        #1;
        check("rst2_io_out", {16'd0, io_out}, 32'h0);
        check("rst2_err", {31'd0, err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
